// File: rtl/jt51_exp_addr_if.sv
// Operator log-to-linear front-end bus: log-sine/envelope inputs and exp-ROM side-band outputs.
// With JT51_EXP_MUTE_EN defined the bus also carries a per-slot mute_mask.
interface jt51_exp_addr_if;
    // No valid/ready: clk_en alone qualifies each sample; the pipeline never stalls.
    logic        clk_en;
    logic        zero;
    logic [11:0] sin_log;
    logic        sin_sign;
    logic [9:0]  eg_att;
`ifdef JT51_EXP_MUTE_EN
    logic [31:0] mute_mask;
`endif
    logic [4:0]  rom_addr;
    logic [2:0]  fine;
    logic [4:0]  shift;
    logic        sign;
    logic        silent;
    logic [4:0]  slot;

`ifdef JT51_EXP_MUTE_EN
    modport master (output clk_en, zero, sin_log, sin_sign, eg_att, mute_mask,
                    input  rom_addr, fine, shift, sign, silent, slot);
    modport slave  (input  clk_en, zero, sin_log, sin_sign, eg_att, mute_mask,
                    output rom_addr, fine, shift, sign, silent, slot);
`else
    modport master (output clk_en, zero, sin_log, sin_sign, eg_att,
                    input  rom_addr, fine, shift, sign, silent, slot);
    modport slave  (input  clk_en, zero, sin_log, sin_sign, eg_att,
                    output rom_addr, fine, shift, sign, silent, slot);
`endif
endinterface

// File: rtl/jt51_exp_addr.sv
// Adds log-sine and envelope attenuation, splits the sum into exp-ROM address, fine index
// and shift, and delays side-band fields to match the ROM. Optional: JT51_EXP_MUTE_EN.
module jt51_exp_addr #(
    parameter int SHIFT_MAX = 13
) (
    input  logic            clk,
    input  logic            rst,
    jt51_exp_addr_if.slave  bus
);

    logic [4:0]  cnt;
    logic [4:0]  s_in;
    logic [12:0] sum_raw;
    logic [12:0] sum;
    logic [2:0]  f1;
    logic [4:0]  sh1;
    logic        sg1;
    logic        sl1;
    logic [4:0]  t1;

    assign s_in    = bus.zero ? 5'd0 : cnt;
    assign sum_raw = {1'b0, bus.sin_log} + {1'b0, bus.eg_att, 2'b00};

`ifdef JT51_EXP_MUTE_EN
    // All-ones sum lands on the quietest ROM entry with a silent-level shift.
    assign sum = bus.mute_mask[s_in] ? 13'h1FFF : sum_raw;
`else
    assign sum = sum_raw;
`endif

    // Stage 1: ROM address plus side-band fields waiting for the ROM's registered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 5'd0;
            bus.rom_addr <= 5'd0;
            f1           <= 3'd0;
            sh1          <= 5'd0;
            sg1          <= 1'b0;
            sl1          <= 1'b1;
            t1           <= 5'd0;
        end else if (bus.clk_en) begin
            cnt          <= s_in + 5'd1;
            bus.rom_addr <= sum[7:3];
            f1           <= sum[2:0];
            sh1          <= sum[12:8];
            sg1          <= bus.sin_sign;
            sl1          <= (sum[12:8] >= 5'(SHIFT_MAX));
            t1           <= s_in;
        end
    end

    // Stage 2: in step with the exp word coming out of jt51_exprom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fine   <= 3'd0;
            bus.shift  <= 5'd0;
            bus.sign   <= 1'b0;
            bus.silent <= 1'b1;
            bus.slot   <= 5'd0;
        end else if (bus.clk_en) begin
            bus.fine   <= f1;
            bus.shift  <= sh1;
            bus.sign   <= sg1;
            bus.silent <= sl1;
            bus.slot   <= t1;
        end
    end

endmodule

// File: tb/tb_jt51_exp_addr.sv
// Bench for jt51_exp_addr: hand-derived vector table plus model-driven sequences,
// checked through rom_addr and side-band expected queues.
module tb_jt51_exp_addr;

    logic clk;
    logic rst;
    jt51_exp_addr_if bus ();

    jt51_exp_addr #(.SHIFT_MAX(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // side-band packed as {fine, shift, sign, silent, slot}
    localparam logic [14:0] SIDE_RST = {3'd0, 5'd0, 1'b0, 1'b1, 5'd0};

    logic [4:0]  addr_q[$];
    logic [14:0] exp_q[$];
    logic [4:0]  last_addr;
    logic [14:0] last_side;
    logic [4:0]  m_cnt;
    logic [31:0] mask_v;
    int          n_cmp;
    int          n_bad;

    typedef struct {
        logic [11:0] sin_log;
        logic        sin_sign;
        logic [9:0]  eg_att;
        logic [4:0]  e_addr;
        logic [2:0]  e_fine;
        logic [4:0]  e_shift;
        logic        e_silent;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [14:0] side_now();
        return {bus.fine, bus.shift, bus.sign, bus.silent, bus.slot};
    endfunction

    task automatic cmp_addr(input string name, input logic [4:0] exp_v);
        n_cmp++;
        if (bus.rom_addr !== exp_v) begin
            n_bad++;
            $display("FAIL %s rom_addr: got %0d expected %0d", name, bus.rom_addr, exp_v);
        end
    endtask

    task automatic cmp_side(input string name, input logic [14:0] exp_v);
        logic [14:0] got;
        got = side_now();
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s side: got fine=%0d shift=%0d sign=%0d silent=%0d slot=%0d expected fine=%0d shift=%0d sign=%0d silent=%0d slot=%0d",
                     name, got[14:12], got[11:7], got[6], got[5], got[4:0],
                     exp_v[14:12], exp_v[11:7], exp_v[6], exp_v[5], exp_v[4:0]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.clk_en   = 1'b0;
        bus.zero     = 1'b0;
        bus.sin_log  = 12'd0;
        bus.sin_sign = 1'b0;
        bus.eg_att   = 10'd0;
        addr_q.delete();
        exp_q.delete();
        exp_q.push_back(SIDE_RST);
        m_cnt     = 5'd0;
        last_addr = 5'd0;
        last_side = SIDE_RST;
        repeat (3) @(posedge clk);
        #1;
        cmp_addr("reset", last_addr);
        cmp_side("reset", last_side);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver: one clk_en sample; tbl selects table-supplied expectations over the model.
    task automatic step(input string name, input logic z, input logic [11:0] sl, input logic sg,
                        input logic [9:0] eg, input logic tbl, input logic [4:0] t_addr,
                        input logic [2:0] t_fine, input logic [4:0] t_shift, input logic t_sil);
        logic [4:0]  s;
        logic [12:0] sm;
        logic [4:0]  ea;
        logic [2:0]  ef;
        logic [4:0]  es;
        logic        esil;
        @(negedge clk);
        bus.clk_en   = 1'b1;
        bus.zero     = z;
        bus.sin_log  = sl;
        bus.sin_sign = sg;
        bus.eg_att   = eg;
        s     = z ? 5'd0 : m_cnt;
        m_cnt = s + 5'd1;
        sm    = 13'(sl) + 13'(eg) * 13'd4;
        if (mask_v[s]) sm = 13'h1FFF;
        ea   = sm[7:3];
        ef   = sm[2:0];
        es   = sm[12:8];
        esil = (es >= 5'd13);
        if (tbl) begin
            ea = t_addr; ef = t_fine; es = t_shift; esil = t_sil;
        end
        addr_q.push_back(ea);
        exp_q.push_back({ef, es, sg, esil, s});
        @(posedge clk);
        #1;
        bus.clk_en = 1'b0;
        last_addr = addr_q.pop_front();
        last_side = exp_q.pop_front();
        cmp_addr(name, last_addr);
        cmp_side(name, last_side);
    endtask

    task automatic auto_step(input string name, input logic z);
        step(name, z, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 1023)), 1'b0, 5'd0, 3'd0, 5'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cmp_addr("freeze", last_addr);
            cmp_side("freeze", last_side);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        mask_v = 32'd0;
`ifdef JT51_EXP_MUTE_EN
        bus.mute_mask = mask_v;
`endif
        vecs[0] = '{12'h0AB, 1'b0, 10'h005, 5'd23, 3'd7, 5'd0,  1'b0};
        vecs[1] = '{12'hFFF, 1'b1, 10'h3FF, 5'd31, 3'd3, 5'd31, 1'b1};
        vecs[2] = '{12'hD00, 1'b0, 10'h000, 5'd0,  3'd0, 5'd13, 1'b1};
        vecs[3] = '{12'hCFF, 1'b1, 10'h000, 5'd31, 3'd7, 5'd12, 1'b0};
        vecs[4] = '{12'h000, 1'b0, 10'h340, 5'd0,  3'd0, 5'd13, 1'b1};
        vecs[5] = '{12'h123, 1'b1, 10'h010, 5'd12, 3'd3, 5'd1,  1'b0};
        vecs[6] = '{12'h001, 1'b0, 10'h3FF, 5'd31, 3'd5, 5'd15, 1'b1};
        vecs[7] = '{12'h800, 1'b1, 10'h0C0, 5'd0,  3'd0, 5'd11, 1'b0};

        do_reset();

        // first post-reset samples: reset side-band on edge 1, slot 0 then 1 after
        step("start0", 1'b1, 12'd0, 1'b0, 10'd0, 1'b0, 5'd0, 3'd0, 5'd0, 1'b0);
        step("start1", 1'b0, 12'd0, 1'b0, 10'd0, 1'b0, 5'd0, 3'd0, 5'd0, 1'b0);
        step("start2", 1'b0, 12'd0, 1'b0, 10'd0, 1'b0, 5'd0, 3'd0, 5'd0, 1'b0);

        for (int i = 0; i < 8; i++)
            step($sformatf("vec%0d", i), 1'b0, vecs[i].sin_log, vecs[i].sin_sign, vecs[i].eg_att,
                 1'b1, vecs[i].e_addr, vecs[i].e_fine, vecs[i].e_shift, vecs[i].e_silent);

        for (int i = 0; i < 40; i++)
            auto_step("slot_run", i == 0);

        for (int i = 0; i < 8; i++)
            auto_step("zero_mid", (i == 3) || (i == 5) || (i == 6));

        idle(5);
        auto_step("after_freeze", 1'b0);
        auto_step("after_freeze", 1'b0);

        // asynchronous reset between clock edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp_addr("async_rst", 5'd0);
        cmp_side("async_rst", SIDE_RST);
        do_reset();
        for (int i = 0; i < 4; i++)
            auto_step("post_rst", i == 0);

`ifdef JT51_EXP_MUTE_EN
        mask_v = 32'h0000_0004;
        bus.mute_mask = mask_v;
        for (int i = 0; i < 6; i++)
            step("mute", i == 0, 12'h0AB, 1'(i), 10'h005, 1'b0, 5'd0, 3'd0, 5'd0, 1'b0);
        mask_v = 32'd0;
        bus.mute_mask = mask_v;
`endif

        for (int i = 0; i < 2; i++)
            auto_step("drain", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
